reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Reset controller for banks of flops that have both an asynchronous and a synchronous reset input. It synchronizes the board-level asynchronous reset and drives per-domain synchronous resets (sync_reset), releasing domains 0..NUM_DOMAINS-1 in order with a fixed cycle spacing. It also services a software soft-reset request through a 4-phase req/ack handshake. It sits at the top of each clock region, ahead of all datapath flops.

Parameters:
NUM_DOMAINS, 4, number of sequenced sync_reset outputs (>=1)
STAGE_DELAY, 8, clk cycles between successive domain releases (>=1)
SYNC_STAGES, 2, flop depth of the reset synchronizer (>=2)
SOFT_HOLD, 16, clk cycles all domains stay asserted during a soft reset (>=1)

Ports:
clk  input  1  single clock for the whole block
async_reset_n  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronized internally
soft_reset_req  input  1  soft-reset request, level, 4-phase handshake
soft_reset_ack  output  1  soft-reset acknowledge
sync_reset  output  NUM_DOMAINS  active-high synchronous reset per domain; bit k drives domain k
rst_done  output  1  high when every domain is released and the FSM is in RUN
busy  output  1  high whenever the state is not RUN

Behaviour:
- Reset: async_reset_n=0 immediately forces:
  - sync_reset = all 1s, rst_done=0, busy=1, soft_reset_ack=0
  - state=HOLD; counter and domain index = 0
  - synchronizer chain cleared to 0
- Synchronizer: rst_sync_n rises at the SYNC_STAGES-th rising edge after async_reset_n rises. Edge n below means the nth rising edge after that release.
- FSM states: HOLD, RELEASE, RUN, SOFT.
- HOLD:
  - Stays in HOLD while rst_sync_n=0.
  - On the first edge with rst_sync_n=1 (edge SYNC_STAGES+1), moves to RELEASE with cnt=0, idx=0.
- RELEASE:
  - cnt increments each edge.
  - When cnt==STAGE_DELAY-1: clear sync_reset[idx], idx++, cnt=0.
  - On the edge that clears bit NUM_DOMAINS-1: move to RUN, rst_done=1 and busy=0 on that same edge.
  - Domain k falls at edge SYNC_STAGES+1+(k+1)*STAGE_DELAY. Defaults: edges 11, 19, 27, 35.
- RUN: edge e with soft_reset_req=1 and soft_reset_ack=0 causes:
  - state=SOFT, sync_reset = all 1s, rst_done=0, busy=1, cnt=0 (all at edge e).
- SOFT:
  - cnt counts.
  - At edge e+SOFT_HOLD: move to RELEASE with cnt=0, idx=0.
  - Domain k then falls at e+SOFT_HOLD+(k+1)*STAGE_DELAY. Defaults: e+24, e+32, e+40, e+48.
- Ack:
  - soft_reset_ack rises on the edge that re-enters RUN after a soft reset.
  - It clears on the first edge where soft_reset_req is sampled 0.
  - While ack=1, a held req does not retrigger. A new request needs req low, then high.
- Req outside RUN:
  - No action in HOLD, RELEASE or SOFT.
  - A req still held high when RUN is first entered after power-on is serviced on the next edge.
  - A req dropped early is lost. No queuing.
- Async reset mid-sequence (RELEASE or SOFT): behaves exactly as the Reset bullet; the sequence restarts from HOLD.
- sync_reset bits are never re-asserted individually. Release order is strictly ascending.
- Counter width: $clog2(max(STAGE_DELAY,SOFT_HOLD))+1. No wrap occurs because every count is terminated by a compare.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package reset_seq_pkg:
  - state typedef, 2-bit encoding: HOLD=0, RELEASE=1, RUN=2, SOFT=3
  - function for counter width
- Sub-module reset_synchronizer:
  - parameter SYNC_STAGES
  - ports clk, async_reset_n, rst_sync_n
  - async assert, synchronous deassert
- reset_sequencer instantiates reset_synchronizer once and holds the FSM, counter, index and output registers.

Test Plan:
1. Power-on, defaults, clk period 20 ns; async_reset_n=0 for 100 ns, then 1 -> sync_reset=4'b1111 until edge 11; then 4'b1110 @11, 4'b1100 @19, 4'b1000 @27, 4'b0000 and rst_done=1 @35.
2. Soft reset after rst_done, req=1 sampled at edge e -> sync_reset=4'b1111 at e; bit 0 falls e+24, bit 3 and rst_done e+48; ack=1 at e+48; req held high -> no retrigger; req=0 -> ack=0 next edge.
3. async_reset_n pulsed low for 5 ns during RELEASE (after edge 20) -> sync_reset=4'b1111 immediately and asynchronously, rst_done=0; release timing restarts and matches scenario 1 relative to the new deassertion.
4. req pulsed high for 1 cycle during RELEASE and dropped before RUN -> no soft reset; rst_done stays 1 after edge 35; ack never rises.
5. NUM_DOMAINS=1, STAGE_DELAY=1, SYNC_STAGES=2 -> sync_reset falls and rst_done rises at edge 4; soft reset with SOFT_HOLD=1 -> release at e+2.
6. req asserted during SOFT of an ongoing soft reset -> ignored; exactly one sequence completes; ack rises once at its end.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared definitions for the reset sequencer:
//     - state_e   : FSM state encoding (HOLD=0, RELEASE=1, RUN=2, SOFT=3)
//     - cnt_width : width of the shared delay counter, sized for the longer of
//                   the per-domain release spacing and the soft-reset hold time
//     - idx_width : width of the domain index (at least one bit)
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SOFT    = 2'd3
    } state_e;

    // One spare bit above $clog2 so the terminal value always fits, even
    // when the longest delay is an exact power of two.
    function automatic int cnt_width(input int stage_delay, input int soft_hold);
        int longest;
        longest = (stage_delay > soft_hold) ? stage_delay : soft_hold;
        return $clog2(longest) + 1;
    endfunction

    // A single-domain build still needs a one-bit index register.
    function automatic int idx_width(input int num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

endpackage : reset_seq_pkg

// File: rtl/reset_synchronizer.sv
// -----------------------------------------------------------------------------
// reset_synchronizer
//   Classic reset bridge: asserts immediately with async_reset_n, deasserts
//   only after SYNC_STAGES rising edges of clk so the release is clean
//   with respect to clk.
//
//   Ports:
//     clk           in   clock of the region being reset
//     async_reset_n in   asynchronous active-low board reset
//     rst_sync_n    out  active-low reset, synchronous deassertion; rises on
//                        the SYNC_STAGES-th rising edge after async_reset_n
//                        goes high
// -----------------------------------------------------------------------------
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_reset_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // A constant 1 is shifted in from the bottom; the top stage is the output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbours and the chain
    // shifts by exactly one stage per edge regardless of statement order.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule : reset_synchronizer

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Drives per-domain synchronous resets for a clock region. After the board
//   reset is released (and synchronized) the domains are released one at a
//   time in ascending order, STAGE_DELAY cycles apart. Once every domain is
//   out of reset the block sits in RUN and can service a software soft-reset
//   request over a 4-phase req/ack handshake: all domains are re-asserted for
//   SOFT_HOLD cycles and then released again in the same ordered fashion.
//
//   Ports:
//     clk            in   single clock for the block
//     async_reset_n  in   asynchronous active-low reset; assertion forces all
//                         outputs to their reset values immediately
//     soft_reset_req in   soft-reset request (level)
//     soft_reset_ack out  soft-reset acknowledge; rises when RUN is re-entered
//                         after a soft reset, falls once req is seen low
//     sync_reset     out  [NUM_DOMAINS] active-high sync reset, bit k = domain k
//     rst_done       out  every domain released and the FSM is in RUN
//     busy           out  FSM is anywhere other than RUN
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_DELAY = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SOFT_HOLD   = 16
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   soft_reset_req,
    output logic                   soft_reset_ack,
    output logic [NUM_DOMAINS-1:0] sync_reset,
    output logic                   rst_done,
    output logic                   busy
);

    localparam int CNT_W = cnt_width(STAGE_DELAY, SOFT_HOLD);
    localparam int IDX_W = idx_width(NUM_DOMAINS);

    // Terminal counts: every count is stopped by one of these compares, so
    // the counter never wraps.
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    // -------------------------------------------------------------------------
    // Reset bridge
    // -------------------------------------------------------------------------
    logic rst_sync_n;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_synchronizer (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .rst_sync_n    (rst_sync_n)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                 state_q,      state_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [IDX_W-1:0]       idx_q,        idx_d;
    logic [NUM_DOMAINS-1:0] sync_reset_q, sync_reset_d;
    logic                   rst_done_q,   rst_done_d;
    logic                   busy_q,       busy_d;
    logic                   ack_q,        ack_d;
    // Remembers that the current release sequence was started by a soft
    // reset, so the ack is raised only for those and not after power-on.
    logic                   soft_q,       soft_d;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so
        // no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sync_reset_d = sync_reset_q;
        rst_done_d   = rst_done_q;
        busy_d       = busy_q;
        soft_d       = soft_q;
        // Ack holds only while req stays high; the first low sample drops it.
        ack_d        = ack_q & soft_reset_req;

        case (state_q)
            ST_HOLD: begin
                if (rst_sync_n) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            sync_reset_d[k] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_RUN;
                        rst_done_d = 1'b1;
                        busy_d     = 1'b0;
                        if (soft_q) begin
                            ack_d  = 1'b1;
                            soft_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // A held req with ack still high is the tail of the previous
                // handshake, not a new request.
                if (soft_reset_req && !ack_q) begin
                    state_d      = ST_SOFT;
                    sync_reset_d = '1;
                    rst_done_d   = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    soft_d       = 1'b1;
                end
            end

            ST_SOFT: begin
                if (cnt_q == SOFT_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers: the raw asynchronous reset is used so that assertion reaches
    // the outputs without waiting for a clock edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            sync_reset_q <= '1;
            rst_done_q   <= 1'b0;
            busy_q       <= 1'b1;
            ack_q        <= 1'b0;
            soft_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sync_reset_q <= sync_reset_d;
            rst_done_q   <= rst_done_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            soft_q       <= soft_d;
        end
    end

    assign sync_reset     = sync_reset_q;
    assign rst_done       = rst_done_q;
    assign busy           = busy_q;
    assign soft_reset_ack = ack_q;

endmodule : reset_sequencer
